// File: rtl/complex_butterfly_pipe.sv
// complex_butterfly_pipe
//   Two-stage pipelined radix-2 butterfly. Each accepted pair (A, B) of packed
//   complex words {real, imag} produces A+B and A-B. Valid/ready handshakes on
//   both sides. Stage 1 registers the operands. Stage 2 registers the results.
//   Outputs come straight from stage 2, so there is no combinational path from
//   i_A/i_B to the outputs.
//
//   Optional build macro: COMPLEX_BUTTERFLY_SAT_EN
//     undefined : each component wraps modulo 2^WIDTH (two's complement)
//     defined   : each component is computed at WIDTH+1 bits and saturated
//                 to [-2^(WIDTH-1), 2^(WIDTH-1)-1]
//   Latency, handshake and reset behaviour are the same in both builds.

module complex_butterfly_pipe #(
  parameter int WIDTH = 8
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [2*WIDTH-1:0] i_A,
  input  logic [2*WIDTH-1:0] i_B,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [2*WIDTH-1:0] o_sum,
  output logic [2*WIDTH-1:0] o_diff
);

  localparam int DW = 2 * WIDTH;

  // Combines one real or imag component. The real and imag halves are always
  // handled by separate calls, so no carry or borrow crosses between them.
`ifdef COMPLEX_BUTTERFLY_SAT_EN
  function automatic logic [WIDTH-1:0] f_combine(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b,
                                                 input logic             sub);
    logic [WIDTH:0] ext;
    logic [WIDTH-1:0] res;
    ext = sub ? ({a[WIDTH-1], a} - {b[WIDTH-1], b})
              : ({a[WIDTH-1], a} + {b[WIDTH-1], b});
    // The top two bits disagree only when the true result lies outside the
    // WIDTH-bit range; the sign bit then says which rail to clamp to.
    if (ext[WIDTH] != ext[WIDTH-1]) begin
      res = ext[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      res = ext[WIDTH-1:0];
    end
    return res;
  endfunction
`else
  function automatic logic [WIDTH-1:0] f_combine(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b,
                                                 input logic             sub);
    // WIDTH-bit arithmetic drops the carry out, which is exactly the
    // two's-complement wrap-around.
    return sub ? (a - b) : (a + b);
  endfunction
`endif

  // Stage 1: captured operands
  logic          r_s1_valid;
  logic [DW-1:0] r_s1_a;
  logic [DW-1:0] r_s1_b;

  // Stage 2: computed results, which drive the outputs
  logic          r_s2_valid;
  logic [DW-1:0] r_s2_sum;
  logic [DW-1:0] r_s2_diff;

  // Advance enables and stage-1 arithmetic
  logic          w_adv1;
  logic          w_adv2;
  logic [DW-1:0] w_sum;
  logic [DW-1:0] w_diff;

  // Stage advance: a stage moves when it is empty or its consumer takes data.
  // This depends only on the stage flags and i_ready, never on i_valid.
  always_comb begin
    w_adv2 = !r_s2_valid || i_ready;
    w_adv1 = !r_s1_valid || w_adv2;
  end

  // Butterfly arithmetic on the stage-1 operands, one component at a time
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path through
    // the block can leave it unassigned and infer a latch.
    w_sum  = '0;
    w_diff = '0;
    w_sum[DW-1:WIDTH]  = f_combine(r_s1_a[DW-1:WIDTH], r_s1_b[DW-1:WIDTH], 1'b0);
    w_sum[WIDTH-1:0]   = f_combine(r_s1_a[WIDTH-1:0],  r_s1_b[WIDTH-1:0],  1'b0);
    w_diff[DW-1:WIDTH] = f_combine(r_s1_a[DW-1:WIDTH], r_s1_b[DW-1:WIDTH], 1'b1);
    w_diff[WIDTH-1:0]  = f_combine(r_s1_a[WIDTH-1:0],  r_s1_b[WIDTH-1:0],  1'b1);
  end

  // Control flags and stage-2 results, with synchronous reset
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values that were present before the clock edge.
    if (!i_rst_n) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
      r_s2_sum   <= '0;
      r_s2_diff  <= '0;
    end else begin
      if (w_adv1) begin
        r_s1_valid <= i_valid;
      end
      if (w_adv2) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_s2_sum  <= w_sum;
          r_s2_diff <= w_diff;
        end
      end
    end
  end

  // Stage-1 operand capture on an accepted transfer
  always_ff @(posedge i_clk) begin
    // NOTE: stage-1 data is not reset. It is only ever consumed while
    // r_s1_valid is set, and that flag is reset, so clearing it saves nothing.
    if (w_adv1 && i_valid) begin
      r_s1_a <= i_A;
      r_s1_b <= i_B;
    end
  end

  assign o_ready = w_adv1;
  assign o_valid = r_s2_valid;
  assign o_sum   = r_s2_sum;
  assign o_diff  = r_s2_diff;

endmodule

// File: tb/tb_complex_butterfly_pipe.sv
// tb_complex_butterfly_pipe
//   Directed and random stimulus for complex_butterfly_pipe. A transaction-level
//   reference model (a queue of expected results with their ages) predicts
//   o_ready, o_valid, o_sum and o_diff. Honours COMPLEX_BUTTERFLY_SAT_EN.

module tb_complex_butterfly_pipe;

  localparam int W  = 8;
  localparam int DW = 2 * W;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] a;
  logic [DW-1:0] b;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] sum;
  logic [DW-1:0] diff;

  complex_butterfly_pipe #(.WIDTH(W)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_valid (in_valid),
    .o_ready (in_ready),
    .i_A     (a),
    .i_B     (b),
    .o_valid (out_valid),
    .i_ready (out_ready),
    .o_sum   (sum),
    .o_diff  (diff)
  );

  always #5 clk = ~clk;

  // Reference model: results held inside the DUT, oldest first. age counts the
  // clock edges since the pair was accepted. A result is visible once it is at
  // least two edges old and it is the oldest one in the block.
  typedef struct {
    logic [DW-1:0] sum;
    logic [DW-1:0] diff;
    int            age;
  } item_t;

  item_t q[$];
  int    n_cmp   = 0;
  int    n_fail  = 0;
  int    n_drain = 0;
  int    n_cycle = 0;
  bit    last_acc;
  bit    last_drn;

  // One component, computed from plain integer arithmetic
  function automatic logic [W-1:0] ref_comp(input logic [W-1:0] x,
                                            input logic [W-1:0] y,
                                            input bit           sub);
    int xs;
    int ys;
    int r;
    logic [31:0] rv;
    xs = int'($signed(x));
    ys = int'($signed(y));
    r  = sub ? (xs - ys) : (xs + ys);
`ifdef COMPLEX_BUTTERFLY_SAT_EN
    if (r > (1 << (W - 1)) - 1) r = (1 << (W - 1)) - 1;
    if (r < -(1 << (W - 1)))    r = -(1 << (W - 1));
`endif
    rv = r;
    return rv[W-1:0];
  endfunction

  function automatic logic [DW-1:0] ref_word(input logic [DW-1:0] x,
                                             input logic [DW-1:0] y,
                                             input bit            sub);
    return {ref_comp(x[DW-1:W], y[DW-1:W], sub), ref_comp(x[W-1:0], y[W-1:0], sub)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: check outputs mid-cycle against the model, then advance
  // the model by the handshakes that happen at the rising edge.
  task automatic tick();
    bit ev;
    bit er;
    @(negedge clk);
    ev = (q.size() > 0) && (q[0].age >= 2);
    er = (q.size() < 2) || out_ready;
    check("o_ready", in_ready, er);
    check("o_valid", out_valid, ev);
    if (ev) begin
      check("o_sum", sum, q[0].sum);
      check("o_diff", diff, q[0].diff);
    end
    last_acc = in_valid && er;
    last_drn = ev && out_ready;
    @(posedge clk);
    #1;
    n_cycle++;
    if (!rst_n) begin
      q.delete();
      last_acc = 1'b0;
      last_drn = 1'b0;
    end else begin
      foreach (q[i]) q[i].age++;
      if (last_drn) begin
        void'(q.pop_front());
        n_drain++;
      end
      if (last_acc) q.push_back('{sum: ref_word(a, b, 1'b0), diff: ref_word(a, b, 1'b1), age: 1});
    end
  endtask

  logic [DW-1:0] pa [4];
  logic [DW-1:0] pb [4];
  int idx;
  int n_acc;
  int d0;
  int first_drn;
  int last_drn_cycle;

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    repeat (2) @(posedge clk);
    #1;
    // Reset state
    check("rst_o_valid", out_valid, 1'b0);
    check("rst_o_sum", sum, 16'h0000);
    check("rst_o_diff", diff, 16'h0000);
    check("rst_o_ready", in_ready, 1'b1);
    rst_n = 1'b1;

    // Test 1: basic pair, result two cycles after acceptance
    out_ready = 1'b1;
    in_valid = 1'b1; a = 16'h0421; b = 16'h0224;
    tick();
    check("t1_accept", last_acc, 1'b1);
    in_valid = 1'b0;
    tick();
    check("t1_valid", out_valid, 1'b1);
    check("t1_sum", sum, 16'h0645);
    check("t1_diff", diff, 16'h02FD);
    tick();

    // Test 2: negative operands
    in_valid = 1'b1; a = 16'hFFFE; b = 16'hFE05;
    tick();
    in_valid = 1'b0;
    tick();
    check("t2_valid", out_valid, 1'b1);
    check("t2_sum", sum, 16'hFD03);
    check("t2_diff", diff, 16'h01F9);
    tick();

    // Test 3: overflow on real sum and imag difference
    in_valid = 1'b1; a = 16'h7F80; b = 16'h0101;
    tick();
    in_valid = 1'b0;
    tick();
    check("t3_valid", out_valid, 1'b1);
`ifdef COMPLEX_BUTTERFLY_SAT_EN
    check("t3_sum_real", sum[15:8], 8'h7F);
    check("t3_diff_imag", diff[7:0], 8'h80);
`else
    check("t3_sum_real", sum[15:8], 8'h80);
    check("t3_diff_imag", diff[7:0], 8'h7F);
`endif
    tick();

    // Test 4: backpressure - two pairs fit, then o_ready drops
    for (int i = 0; i < 4; i++) begin
      pa[i] = DW'($urandom);
      pb[i] = DW'($urandom);
    end
    out_ready = 1'b0;
    idx = 0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; a = pa[idx]; b = pb[idx];
      tick();
      if (last_acc) idx++;
    end
    check("t4_accepts_stalled", idx, 2);
    check("t4_ready_low", in_ready, 1'b0);
    repeat (3) begin
      tick();
      check("t4_hold_valid", out_valid, 1'b1);
      check("t4_hold_sum", sum, ref_word(pa[0], pb[0], 1'b0));
      check("t4_hold_diff", diff, ref_word(pa[0], pb[0], 1'b1));
    end
    out_ready = 1'b1;
    d0 = n_drain;
    for (int i = 0; i < 20 && idx < 4; i++) begin
      in_valid = 1'b1; a = pa[idx]; b = pb[idx];
      tick();
      if (last_acc) idx++;
    end
    check("t4_all_accepted", idx, 4);
    in_valid = 1'b0;
    for (int i = 0; i < 10 && q.size() > 0; i++) tick();
    check("t4_drained", n_drain - d0, 4);
    tick();

    // Test 5: 16 back-to-back pairs at full throughput
    n_acc = 0;
    d0 = n_drain;
    first_drn = -1;
    last_drn_cycle = -1;
    for (int i = 0; i < 18; i++) begin
      in_valid = (i < 16);
      a = DW'($urandom);
      b = DW'($urandom);
      tick();
      if (last_acc) n_acc++;
      if (last_drn) begin
        if (first_drn < 0) first_drn = i;
        last_drn_cycle = i;
      end
    end
    check("t5_accepts", n_acc, 16);
    check("t5_results", n_drain - d0, 16);
    check("t5_first_result_cycle", first_drn, 2);
    check("t5_last_result_cycle", last_drn_cycle, 17);

    // Test 6: reset with two pairs in flight
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; a = DW'($urandom); b = DW'($urandom);
      tick();
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    check("t6_o_valid", out_valid, 1'b0);
    check("t6_o_sum", sum, 16'h0000);
    check("t6_o_diff", diff, 16'h0000);
    check("t6_o_ready", in_ready, 1'b1);
    rst_n = 1'b1;
    d0 = n_drain;
    repeat (6) tick();
    check("t6_no_stale", n_drain - d0, 0);

    // Random traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      a = DW'($urandom);
      b = DW'($urandom);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 10 && q.size() > 0; i++) tick();
    check("rand_drained", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
